// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key scheduler.
// Loaded with the round-10 key, it walks the key schedule backwards and
// presents one round key per handshake, rounds 10 down to 0. Only the
// current round key is held, so the decryptor never needs the full schedule.
//
// Vectors use big-endian bit order: word 0 of a key is bits [0:31].
//
// sbox ports:
//   in_i   [0:7] byte to substitute
//   out_o  [0:7] AES forward S-box of in_i
//
// aes_inv_key_sched ports:
//   clk, rst      clock and synchronous active-high reset
//   start         load request, honoured only while idle
//   last_key      round-10 key, captured together with start
//   out_valid     round_key / round_idx are valid
//   out_ready     consumer takes the current key
//   round_key     current round key
//   round_idx     round number of round_key (10 .. 0)
//   busy          a stream is in progress
//   done          one-cycle pulse after the round-0 key is taken

// AES forward S-box lookup.
module sbox (
  input  logic [0:7] in_i,
  output logic [0:7] out_o
);

  localparam logic [7:0] SBOX_TAB [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_o = SBOX_TAB[in_i];

endmodule

module aes_inv_key_sched #(
  parameter int unsigned N_ROUND = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [0:127] last_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] round_key,
  output logic [0:3]   round_idx,
  output logic         busy,
  output logic         done
);

  localparam int unsigned KEY_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [0:KEY_W-1]    key_q, key_d;
  logic [0:IDX_W-1]    idx_q, idx_d;
  logic                done_q, done_d;

  logic [0:WORD_W-1]   w0, w1, w2, w3;
  logic [0:WORD_W-1]   p0, p1, p2, p3;
  logic [0:WORD_W-1]   rot_w, sub_w;
  logic [0:BYTE_W-1]   rcon;
  logic [0:KEY_W-1]    prev_key;

  // Previous round key from the current one: undo the word chain, then
  // recover word 0 through the g() function of the recovered word 3.
  assign w0 = key_q[0*WORD_W +: WORD_W];
  assign w1 = key_q[1*WORD_W +: WORD_W];
  assign w2 = key_q[2*WORD_W +: WORD_W];
  assign w3 = key_q[3*WORD_W +: WORD_W];

  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

  // RotWord: byte 0 moves to the last byte position.
  assign rot_w = {p3[BYTE_W:WORD_W-1], p3[0:BYTE_W-1]};

  for (genvar b = 0; b < 4; b++) begin : gen_sub
    sbox u_sbox (
      .in_i  (rot_w[b*BYTE_W +: BYTE_W]),
      .out_o (sub_w[b*BYTE_W +: BYTE_W])
    );
  end

  // Round constant of the key being undone (round idx_q).
  always_comb begin
    rcon = 8'h00;
    case (idx_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign p0       = w0 ^ sub_w ^ {rcon, 24'h000000};
  assign prev_key = {p0, p1, p2, p3};

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          key_d   = last_key;
          idx_d   = IDX_W'(N_ROUND);
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (idx_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d = prev_key;
            idx_d = idx_q - IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = (state_q == STREAM);
  assign busy      = (state_q == STREAM);
  assign round_key = key_q;
  assign round_idx = idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: a cycle model driven by a word-array
// reconstruction of the AES-128 key schedule, plus directed scenarios.
module tb_aes_inv_key_sched;

  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] ALT_KEY  = 128'h0123456789abcdeffedcba9876543210;

  typedef logic [10:0][127:0] sched_t;

  logic         clk = 1'b0;
  logic         rst, start, out_ready;
  logic [0:127] last_key;
  logic         out_valid, busy, done;
  logic [0:127] round_key;
  logic [0:3]   round_idx;

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt = 0;

  logic [7:0] tb_sbox [256];

  always #5 clk = ~clk;

  aes_inv_key_sched #(.N_ROUND(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .last_key  (last_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // GF(2^8) arithmetic used to derive the S-box and round constants.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    d = d << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] rcon_of(input int r);
    logic [7:0] v = 8'h01;
    for (int j = 1; j < r; j++) v = gmul(v, 8'h02);
    return v;
  endfunction

  function automatic logic [31:0] g_fn(input logic [31:0] x, input int r);
    logic [31:0] y = {x[23:0], x[31:24]};
    for (int b = 0; b < 4; b++) y[b*8 +: 8] = tb_sbox[y[b*8 +: 8]];
    return y ^ {rcon_of(r), 24'h000000};
  endfunction

  // Whole schedule as 44 words, filled from the top down.
  function automatic sched_t inv_sched(input logic [127:0] k10);
    logic [31:0] w [44];
    logic [31:0] t;
    sched_t s;
    for (int j = 0; j < 4; j++) w[40+j] = k10[127-32*j -: 32];
    for (int i = 43; i >= 4; i--) begin
      t = w[i-1];
      if (i % 4 == 0) t = g_fn(t, i / 4);
      w[i-4] = w[i] ^ t;
    end
    for (int r = 0; r <= 10; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return s;
  endfunction

  // Standard forward expansion; returns the round-10 key.
  function automatic logic [127:0] fwd_k10(input logic [127:0] k0);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int j = 0; j < 4; j++) w[j] = k0[127-32*j -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = g_fn(t, i / 4);
      w[i] = w[i-4] ^ t;
    end
    return {w[40], w[41], w[42], w[43]};
  endfunction

  // Cycle model: compare outputs at each falling edge, then advance using
  // the inputs that the next rising edge will sample.
  initial begin : monitor
    logic       m_active = 1'b0;
    logic       m_done   = 1'b0;
    int         m_idx    = 0;
    logic [127:0] m_key  = '0;
    sched_t     m_sched;
    forever begin
      @(negedge clk);
      chk("out_valid", 128'(out_valid), 128'(m_active));
      chk("busy",      128'(busy),      128'(m_active));
      chk("done",      128'(done),      128'(m_done));
      chk("round_idx", 128'(round_idx), 128'(m_idx));
      chk("round_key", 128'(round_key), m_key);
      if (done === 1'b1) done_cnt++;
      m_done = 1'b0;
      if (rst) begin
        m_active = 1'b0;
        m_idx    = 0;
        m_key    = '0;
      end else if (!m_active) begin
        if (start) begin
          m_sched  = inv_sched(last_key);
          m_active = 1'b1;
          m_idx    = 10;
          m_key    = m_sched[10];
        end
      end else if (out_ready) begin
        if (m_idx == 0) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end else begin
          m_idx = m_idx - 1;
          m_key = m_sched[m_idx];
        end
      end
    end
  end

  task automatic pulse_start(input logic [127:0] k);
    @(posedge clk); #1;
    start    = 1'b1;
    last_key = k;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // mode 0: ready held, 1: random ready, 2: ready held plus start at idx 5.
  task automatic wait_done(input int mode, input int max_cyc, output int n);
    logic injected = 1'b0;
    n = 0;
    while (1) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (done === 1'b1) break;
      if (n >= max_cyc) begin
        n_checks++;
        n_err++;
        $display("FAIL wait_done: timeout after %0d cycles, done=%b", n, done);
        break;
      end
      if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      if (mode == 2 && !injected && round_idx == 4'd5) begin
        start    = 1'b1;
        last_key = ALT_KEY;
        injected = 1'b1;
      end
    end
    out_ready = 1'b1;
  endtask

  initial begin : main
    sched_t s;
    int     n, d0, k;
    logic [7:0] inv;

    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    last_key  = '0;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      tb_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    // Pin the model against published values.
    s = inv_sched(FIPS_K10);
    chk("model_fips_k9", s[9], FIPS_K9);
    chk("model_fips_k1", s[1], FIPS_K1);
    chk("model_fips_k0", s[0], FIPS_K0);
    chk("model_fwd_k10", fwd_k10(s[0]), FIPS_K10);
    s = inv_sched(ZERO_K10);
    chk("model_zero_k0", s[0], 128'h0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // FIPS vector, ready held high.
    out_ready = 1'b1;
    d0 = done_cnt;
    pulse_start(FIPS_K10);
    chk("load_valid", 128'(out_valid), 128'd1);
    chk("load_idx",   128'(round_idx), 128'd10);
    chk("load_key",   128'(round_key), FIPS_K10);
    wait_done(0, 60, n);
    chk("done_latency", 128'(n), 128'd11);
    chk("done_busy",    128'(busy), 128'd0);

    // Back-to-back: start in the done cycle with the zero-key vector.
    start    = 1'b1;
    last_key = ZERO_K10;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_valid", 128'(out_valid), 128'd1);
    chk("b2b_idx",   128'(round_idx), 128'd10);
    chk("b2b_key",   128'(round_key), ZERO_K10);
    wait_done(0, 60, n);
    repeat (3) @(posedge clk);
    #1;
    chk("zero_k0_hold",  128'(round_key), 128'h0);
    chk("zero_idx_hold", 128'(round_idx), 128'd0);
    chk("done_count_12", 128'(done_cnt - d0), 128'd2);

    // Backpressure with random ready.
    d0 = done_cnt;
    out_ready = 1'b0;
    pulse_start(FIPS_K10);
    wait_done(1, 400, n);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_done_count", 128'(done_cnt - d0), 128'd1);
    chk("bp_k0_hold",    128'(round_key), FIPS_K0);

    // Start while busy is ignored; no pending load afterwards.
    d0 = done_cnt;
    pulse_start(FIPS_K10);
    wait_done(2, 60, n);
    chk("busy_start_latency", 128'(n), 128'd11);
    repeat (5) @(posedge clk);
    #1;
    chk("busy_start_idle",  128'(out_valid), 128'd0);
    chk("busy_start_k0",    128'(round_key), FIPS_K0);
    chk("busy_start_dones", 128'(done_cnt - d0), 128'd1);

    // Reset in the middle of a stream.
    pulse_start(FIPS_K10);
    k = 0;
    while (round_idx != 4'd7 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rst_reach_idx7", 128'(round_idx), 128'd7);
    d0  = done_cnt;
    rst = 1'b1;
    start = 1'b1;
    last_key = ALT_KEY;
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_busy",  128'(busy),      128'd0);
    chk("rst_key",   128'(round_key), 128'h0);
    chk("rst_idx",   128'(round_idx), 128'd0);
    chk("rst_done",  128'(done),      128'd0);
    repeat (15) @(posedge clk);
    #1;
    chk("rst_no_done", 128'(done_cnt - d0), 128'd0);
    pulse_start(FIPS_K10);
    wait_done(0, 60, n);
    chk("rst_restart_latency", 128'(n), 128'd11);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_restart_k0", 128'(round_key), FIPS_K0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
